// File: rtl/arith_muldiv.sv
// RV32I/M-style ALU: single-cycle base ops, iterative shift-add multiply and restoring divide.
// Define ARITH_M_EXT_EN to build the M-extension datapath; otherwise metadata 01 encodings are illegal.
module arith_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic [DATA_WIDTH-1:0] rhs,
    input  logic [2:0]            operation,
    input  logic [6:0]            metadata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  illegal
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  result_q, result_d;
    logic          illegal_q, illegal_d;

    logic [W-1:0]  base_res;
    logic          base_ok;
    logic [CW-1:0] shamt;

`ifdef ARITH_M_EXT_EN
    localparam logic [CW-1:0] LAST    = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    // hi/lo hold the running product (MUL) or remainder/quotient (DIV); a holds the other operand.
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d;
    logic [1:0]     op_q, op_d;
    logic           negq_q, negq_d, negr_q, negr_d;
    logic [W:0]     step;
    logic [2*W-1:0] prod;
    logic [W-1:0]   lhs_mag, rhs_mag, quo, rem;
    logic           sgn_a, sgn_b;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef ARITH_M_EXT_EN
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            op_q      <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifdef ARITH_M_EXT_EN
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            a_q       <= a_d;
            op_q      <= op_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
`endif
        end
    end

    always_comb begin
        base_res = '0;
        base_ok  = 1'b1;
        shamt    = rhs[CW-1:0];
        if (metadata == 7'h00) begin
            case (operation)
                3'd0:    base_res = lhs + rhs;
                3'd1:    base_res = lhs << shamt;
                3'd2:    base_res = {{(W-1){1'b0}}, $signed(lhs) < $signed(rhs)};
                3'd3:    base_res = {{(W-1){1'b0}}, lhs < rhs};
                3'd4:    base_res = lhs ^ rhs;
                3'd5:    base_res = lhs >> shamt;
                3'd6:    base_res = lhs | rhs;
                default: base_res = lhs & rhs;
            endcase
        end else if (metadata == 7'h20 && operation == 3'd0) begin
            base_res = lhs - rhs;
        end else if (metadata == 7'h20 && operation == 3'd5) begin
            base_res = W'($signed(lhs) >>> shamt);
        end else begin
            base_ok = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifdef ARITH_M_EXT_EN
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        op_d    = op_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        step    = '0;
        prod    = '0;
        quo     = '0;
        rem     = '0;
        sgn_a   = 1'b0;
        sgn_b   = 1'b0;
        lhs_mag = lhs[W-1] ? -lhs : lhs;
        rhs_mag = rhs[W-1] ? -rhs : rhs;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = DONE;
                    result_d  = base_ok ? base_res : '0;
                    illegal_d = !base_ok;
`ifdef ARITH_M_EXT_EN
                    if (metadata == 7'h01) begin
                        illegal_d = 1'b0;
                        op_d      = operation[1:0];
                        cnt_d     = '0;
                        hi_d      = '0;
                        if (!operation[2]) begin
                            // Multiply unsigned magnitudes, fix the sign at the end.
                            sgn_a  = (operation != 3'd3);
                            sgn_b  = !operation[1];
                            lo_d   = (sgn_a && lhs[W-1]) ? lhs_mag : lhs;
                            a_d    = (sgn_b && rhs[W-1]) ? rhs_mag : rhs;
                            negq_d = (sgn_a && lhs[W-1]) ^ (sgn_b && rhs[W-1]);
                            state_d = MUL;
                        end else begin
                            sgn_a = !operation[0];
                            if (rhs == '0) begin
                                result_d = operation[1] ? lhs : '1;
                            end else if (sgn_a && lhs == MOST_NEG && rhs == '1) begin
                                result_d = operation[1] ? '0 : lhs;
                            end else begin
                                lo_d    = (sgn_a && lhs[W-1]) ? lhs_mag : lhs;
                                a_d     = (sgn_a && rhs[W-1]) ? rhs_mag : rhs;
                                negq_d  = sgn_a && (lhs[W-1] ^ rhs[W-1]);
                                negr_d  = sgn_a && lhs[W-1];
                                state_d = DIV;
                            end
                        end
                    end
`endif
                end
            end
`ifdef ARITH_M_EXT_EN
            MUL: begin
                step  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
                hi_d  = step[W:1];
                lo_d  = {step[0], lo_q[W-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    prod     = negq_q ? -{hi_d, lo_d} : {hi_d, lo_d};
                    result_d = (op_q == 2'd0) ? prod[W-1:0] : prod[2*W-1:W];
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            DIV: begin
                step = {hi_q, lo_q[W-1]} - {1'b0, a_q};
                if (!step[W]) begin
                    hi_d = step[W-1:0];
                    lo_d = {lo_q[W-2:0], 1'b1};
                end else begin
                    hi_d = {hi_q[W-2:0], lo_q[W-1]};
                    lo_d = {lo_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    quo      = negq_q ? -lo_d : lo_d;
                    rem      = negr_q ? -hi_d : hi_d;
                    result_d = op_q[1] ? rem : quo;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_arith_muldiv.sv
// Randomized self-checking bench for arith_muldiv against a plain-arithmetic reference model.
module tb_arith_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] lhs = '0;
    logic [W-1:0] rhs = '0;
    logic [2:0]   operation = '0;
    logic [6:0]   metadata = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         illegal;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arith_muldiv #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lhs       (lhs),
        .rhs       (rhs),
        .operation (operation),
        .metadata  (metadata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: result, illegal flag and cycles from acceptance to out_valid.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] f, input logic [6:0] m,
                                  output logic [31:0] r, output logic ill, output int lat);
        longint sa;
        longint sb;
`ifdef ARITH_M_EXT_EN
        logic [63:0] p;
`endif
        r   = '0;
        ill = 1'b0;
        lat = 1;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        if (m == 7'h00) begin
            case (f)
                3'd0:    r = a + b;
                3'd1:    r = a << b[4:0];
                3'd2:    r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3:    r = (a < b) ? 32'd1 : 32'd0;
                3'd4:    r = a ^ b;
                3'd5:    r = a >> b[4:0];
                3'd6:    r = a | b;
                default: r = a & b;
            endcase
        end else if (m == 7'h20 && f == 3'd0) begin
            r = a - b;
        end else if (m == 7'h20 && f == 3'd5) begin
            r = 32'(sa >>> b[4:0]);
`ifdef ARITH_M_EXT_EN
        end else if (m == 7'h01 && !f[2]) begin
            lat = W + 1;
            case (f[1:0])
                2'd0, 2'd1: p = 64'(sa * sb);
                2'd2:       p = 64'(sa * longint'({32'b0, b}));
                default:    p = {32'b0, a} * {32'b0, b};
            endcase
            r = (f[1:0] == 2'd0) ? p[31:0] : p[63:32];
        end else if (m == 7'h01) begin
            if (b == 32'd0) begin
                r = f[1] ? a : 32'hFFFF_FFFF;
            end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r = f[1] ? 32'd0 : a;
            end else begin
                lat = W + 1;
                if (!f[0]) r = f[1] ? 32'(sa % sb) : 32'(sa / sb);
                else       r = f[1] ? (a % b) : (a / b);
            end
`endif
        end else begin
            ill = 1'b1;
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input logic [6:0] m, input int hold);
        logic [31:0] er;
        logic        ei;
        int          el;
        int          n;
        logic [31:0] got;
        model(a, b, f, m, er, ei, el);
        @(negedge clk);
        check_val("in_ready_idle", 64'(in_ready), 64'd1);
        lhs = a; rhs = b; operation = f; metadata = m;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the latched operands must be used.
        in_valid = 1'b0;
        lhs = $urandom; rhs = $urandom;
        operation = 3'($urandom); metadata = 7'($urandom);
        n = 1;
        while (!out_valid && n < 200) begin
            check_val("busy_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check_val("latency", 64'(n), 64'(el));
        check_val("result", 64'(result), 64'(er));
        check_val("illegal", 64'(illegal), 64'(ei));
        got = result;
        repeat (hold) begin
            @(posedge clk); #1;
            check_val("hold_valid", 64'(out_valid), 64'd1);
            check_val("hold_result", 64'(result), 64'(got));
            check_val("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("release_valid", 64'(out_valid), 64'd0);
        check_val("release_in_ready", 64'(in_ready), 64'd1);
        $display("txn f=%0d m=%02h lhs=%08h rhs=%08h -> result=%08h illegal=%0b latency=%0d",
                 f, m, a, b, got, ei, n);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [6:0] pick_meta();
        case ($urandom_range(0, 3))
            0:       return 7'h00;
            1:       return 7'h20;
            2:       return 7'h01;
            default: return 7'($urandom);
        endcase
    endfunction

    task automatic reset_mid_op();
        int seen;
        @(negedge clk);
        lhs = $urandom; rhs = $urandom; operation = 3'd0; metadata = 7'h01;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_result", 64'(result), 64'd0);
        check_val("rst_illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (W + 5) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_val("stale_valid", 64'(seen), 64'd0);
        check_val("post_rst_in_ready", 64'(in_ready), 64'd1);
        $display("txn reset during MUL -> stale out_valid cycles=%0d", seen);
    endtask

    initial begin
        #12;
        check_val("reset_in_ready", 64'(in_ready), 64'd1);
        check_val("reset_out_valid", 64'(out_valid), 64'd0);
        check_val("reset_result", 64'(result), 64'd0);
        check_val("reset_illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd5, 32'd7, 3'd0, 7'h00, 0);
        run_op(32'hFFFF_FFFF, 32'd2, 3'd3, 7'h01, 0);
        run_op(32'hFFFF_FFFF, 32'd2, 3'd0, 7'h01, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 7'h01, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 7'h01, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 7'h01, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 3'd4, 7'h01, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 3'd6, 7'h01, 0);
        run_op(32'd100, 32'd0, 3'd5, 7'h01, 0);
        run_op(32'd100, 32'd0, 3'd7, 7'h01, 0);
        run_op(32'h8000_00F0, 32'd36, 3'd5, 7'h20, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 3'd2, 7'h00, 0);
        run_op(32'd3, 32'd4, 3'd0, 7'h00, 5);

        for (int i = 0; i < 80; i++) begin
            run_op(pick_operand(), pick_operand(), 3'($urandom), pick_meta(),
                   int'($urandom_range(0, 2)));
        end

        reset_mid_op();
        run_op(32'd21, 32'd21, 3'd0, 7'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arith_muldiv.md
ARITH_MULDIV -- requirements
Module: arith_muldiv

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand/result width W (even, >= 8).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  request present.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-006 The block SHALL have port lhs  input  W  rs1 value.
REQ-007 The block SHALL have port rhs  input  W  rs2 value or decoded immediate.
REQ-008 The block SHALL have port operation  input  3  funct3.
REQ-009 The block SHALL have port metadata  input  7  funct7, or imm[11:5] (zero if none).
REQ-010 The block SHALL have port out_valid  output  1  result present.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-012 The block SHALL have port result  output  W  operation result.
REQ-013 The block SHALL have port illegal  output  1  unsupported encoding; qualified by out_valid.

Function
REQ-014 The block SHALL implement states IDLE, MUL, DIV and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a request SHALL be accepted when in_valid and in_ready are both 1.
REQ-016 lhs, rhs, operation and metadata SHALL be latched at acceptance; later changes SHALL be ignored.
REQ-017 in_valid outside IDLE SHALL be ignored.
REQ-018 Base ops (metadata 00: funct3 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND; metadata 20: funct3 0 SUB, 5 SRA) SHALL go IDLE->DONE, with out_valid 1 cycle after acceptance.
REQ-019 Shift amount SHALL be rhs[$clog2(W)-1:0]; SLT/SLTU result SHALL be zero-extended 0 or 1.
REQ-020 metadata 01 with funct3 0-3 (MUL, MULH, MULHSU, MULHU) SHALL spend exactly W cycles in MUL (iterative shift-add), then enter DONE; latency W+1.
REQ-021 MUL SHALL return low W bits; MULH, MULHSU and MULHU SHALL return high W bits of the 2W product; MULH is signed x signed, MULHSU is signed x unsigned, MULHU is unsigned x unsigned.
REQ-022 metadata 01 with funct3 4-7 (DIV, DIVU, REM, REMU) SHALL spend exactly W cycles in DIV (restoring), then enter DONE; latency W+1.
REQ-023 Division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero SHALL bypass DIV with latency 1: quotient all-ones, remainder lhs.
REQ-025 Signed overflow (lhs = most negative, rhs = all-ones) SHALL bypass DIV with latency 1: quotient lhs, remainder 0.
REQ-026 Any other encoding SHALL go to DONE with latency 1, illegal 1 and result 0.
REQ-027 In DONE, out_valid SHALL be 1 and result/illegal SHALL be held stable until out_ready is 1.
REQ-028 DONE with out_ready 1 SHALL go to IDLE; the next acceptance SHALL occur no earlier than the following cycle.
REQ-029 out_valid SHALL be 0 in every state other than DONE.

Reset
REQ-030 When rst is 1, the block SHALL immediately enter IDLE: in_ready 1, out_valid 0, result 0, illegal 0, iteration counter 0.
REQ-031 Reset during MUL, DIV or DONE SHALL abort the operation, and no result from it SHALL appear after release.

Configuration
REQ-032 Macro ARITH_M_EXT_EN defined: REQ-020 to REQ-025 SHALL apply.
REQ-033 Macro ARITH_M_EXT_EN undefined: the MUL/DIV states and datapath SHALL be absent, and all metadata-01 encodings SHALL be illegal per REQ-026.

Verification
REQ-034 ADD, lhs 5, rhs 7 -> out_valid 1 cycle after accept, result 0x0000000C, illegal 0.
REQ-035 MULHU 0xFFFFFFFF x 2 -> result 0x00000001 at latency 33; MUL of same operands -> 0xFFFFFFFE; MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at latency 1; REM same -> 0; DIV -7 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF.
REQ-037 DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 / 0 -> 0x00000064; both latency 1.
REQ-038 out_ready held 0 for 5 cycles in DONE -> result stable and in_ready 0; out_ready 1 -> IDLE next cycle, new request accepted.
REQ-039 rst pulsed at MUL cycle 10 -> out_valid 0 and in_ready 1 after release, no stale result; with ARITH_M_EXT_EN undefined, MUL -> illegal 1, result 0, latency 1.
